// File: rtl/fifo_pkg.sv
// Shared FIFO definitions for the read controller and the write controller.
//   clog2 / addr_w : pointer-width helpers; addr_w() never returns less than 1
//   rd_state_t     : read-side state encoding used in first-word-fall-through builds
package fifo_pkg;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FETCH,
    S_VALID
  } rd_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  // A 1-entry address space still needs a 1-bit pointer port.
  function automatic int addr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Registered FIFO pointer that advances on en_i and wraps from DEPTH-1 to 0.
// The wrap is an explicit compare, so DEPTH need not be a power of two.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, pointer returns to 0
//   en_i  : advance the pointer by one entry this cycle
//   ptr_o : current pointer value
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PTR_W = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [PTR_W-1:0] ptr_o
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    // NOTE: the default assignment up front keeps this block free of inferred latches.
    ptr_d = ptr_q;
    if (en_i) ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ONE;
  end

  // NOTE: registered state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: owns the read pointer and the shared occupancy count,
// drives the synchronous-read memory port and registers the popped word.
// Build option: define FIFO_FWFT_EN for first-word-fall-through mode (head word is
// prefetched into rd_data_o; rd_i becomes an acknowledge). Undefined = standard mode.
//   clk, rst        : clock, asynchronous active-high reset
//   wr_i            : push strobe from the write side (accepted iff ~full_o)
//   rd_i            : pop request (standard) / acknowledge (FWFT)
//   mem_rdata_i     : memory read data, valid one cycle after mem_re_o
//   mem_re_o        : memory read enable
//   mem_raddr_o     : memory read address (read pointer)
//   rd_data_o       : registered read data
//   rd_valid_o      : rd_data_o holds a popped word
//   count_o         : entries held in memory, 0..DEPTH
//   full_o, empty_o, almost_empty_o : occupancy status
//   overflow_o      : wr_i while full (push dropped)
//   underflow_o     : rd_i while empty (pop ignored)
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter  int DEPTH    = 32,
  parameter  int DATA_W   = 8,
  parameter  int AE_LEVEL = 2,
  localparam int ADDR_W   = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              push, pop, mem_re;

  assign full_o         = (count_q == DEPTH_C);
  assign almost_empty_o = (count_q <= AE_C);
  assign overflow_o     = wr_i & full_o;
  assign push           = wr_i & ~full_o;
  assign pop            = mem_re;

  // Push and pop in the same cycle cancel, so the count never passes through DEPTH+1 or -1.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  fifo_ptr_wrap #(
    .DEPTH (DEPTH),
    .PTR_W (ADDR_W)
  ) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (pop),
    .ptr_o (mem_raddr_o)
  );

`ifdef FIFO_FWFT_EN
  rd_state_t state_q, state_d;
  logic      capture;

  // The head word lives in rd_data_q while in S_VALID; count only covers the memory.
  always_comb begin
    state_d = state_q;
    mem_re  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (count_q != '0) begin
          mem_re  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        capture = 1'b1;
        state_d = S_VALID;
      end
      S_VALID: begin
        if (rd_i) begin
          if (count_q != '0) begin
            mem_re  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_EMPTY;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) rd_data_q <= mem_rdata_i;
    end
  end

  assign rd_valid_o  = (state_q == S_VALID);
  assign empty_o     = ~rd_valid_o;
  assign underflow_o = rd_i & ~rd_valid_o;
`else
  // Two-stage read: mem_re in N, memory data in N+1, captured word visible in N+2.
  logic re_d1_q, rd_valid_q;

  assign mem_re      = rd_i & (count_q != '0);
  assign empty_o     = (count_q == '0);
  assign underflow_o = rd_i & empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_d1_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      re_d1_q    <= mem_re;
      rd_valid_q <= re_d1_q;
      if (re_d1_q) rd_data_q <= mem_rdata_i;
    end
  end

  assign rd_valid_o = rd_valid_q;
`endif

  assign mem_re_o  = mem_re;
  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed self-checking bench for fifo_rd_ctrl: a DEPTH=32 instance for the main
// sequences and a DEPTH=5 instance for the non-power-of-two pointer wrap.
module tb_fifo_rd_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- DEPTH=32 instance ----------------
  logic       wr = 1'b0, rd = 1'b0;
  logic [7:0] wdat = '0;
  logic [7:0] mem_rdata = '0;
  logic       mem_re, full, empty, almost_empty, overflow, underflow, rd_valid;
  logic [4:0] mem_raddr;
  logic [7:0] rd_data;
  logic [5:0] count;
  logic [7:0] mem [32];
  logic [4:0] wp;

  fifo_rd_ctrl #(.DEPTH(32), .DATA_W(8), .AE_LEVEL(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_i           (wr),
    .rd_i           (rd),
    .mem_rdata_i    (mem_rdata),
    .mem_re_o       (mem_re),
    .mem_raddr_o    (mem_raddr),
    .rd_data_o      (rd_data),
    .rd_valid_o     (rd_valid),
    .count_o        (count),
    .full_o         (full),
    .empty_o        (empty),
    .almost_empty_o (almost_empty),
    .overflow_o     (overflow),
    .underflow_o    (underflow)
  );

  // Write side plus synchronous-read memory surrounding the controller.
  always @(posedge clk or posedge rst) begin
    if (rst) wp <= '0;
    else begin
      if (wr && !full) begin
        mem[wp] <= wdat;
        wp      <= (wp == 5'd31) ? 5'd0 : wp + 5'd1;
      end
      if (mem_re) mem_rdata <= mem[mem_raddr];
    end
  end

  // ---------------- DEPTH=5 instance ----------------
  logic       wr5 = 1'b0, rd5 = 1'b0;
  logic [7:0] wdat5 = '0;
  logic [7:0] mem_rdata5 = '0;
  logic       mem_re5, full5, empty5, ae5, ovf5, unf5, rd_valid5;
  logic [2:0] mem_raddr5;
  logic [7:0] rd_data5;
  logic [3:0] count5;
  logic [7:0] mem5 [5];
  logic [2:0] wp5;

  fifo_rd_ctrl #(.DEPTH(5), .DATA_W(8), .AE_LEVEL(2)) dut5 (
    .clk            (clk),
    .rst            (rst),
    .wr_i           (wr5),
    .rd_i           (rd5),
    .mem_rdata_i    (mem_rdata5),
    .mem_re_o       (mem_re5),
    .mem_raddr_o    (mem_raddr5),
    .rd_data_o      (rd_data5),
    .rd_valid_o     (rd_valid5),
    .count_o        (count5),
    .full_o         (full5),
    .empty_o        (empty5),
    .almost_empty_o (ae5),
    .overflow_o     (ovf5),
    .underflow_o    (unf5)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) wp5 <= '0;
    else begin
      if (wr5 && !full5) begin
        mem5[wp5] <= wdat5;
        wp5       <= (wp5 == 3'd4) ? 3'd0 : wp5 + 3'd1;
      end
      if (mem_re5) mem_rdata5 <= mem5[mem_raddr5];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",    count, 0);
    check("rst_empty",    empty, 1);
    check("rst_ae",       almost_empty, 1);
    check("rst_full",     full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_mem_re",   mem_re, 0);
    check("rst_rd_data",  rd_data, 0);
    check("rst_ovf",      overflow, 0);
    rst = 1'b0;
    tick();

`ifndef FIFO_FWFT_EN
    // ---- underflow at count=0 ----
    rd = 1'b1;
    #2;
    check("unf_flag",   underflow, 1);
    check("unf_mem_re", mem_re, 0);
    tick();
    rd = 1'b0;
    #2;
    check("unf_ptr", mem_raddr, 0);
    tick();
    check("unf_valid", rd_valid, 0);

    // ---- fill 32 ----
    for (int i = 0; i < 32; i++) begin
      wr   = 1'b1;
      wdat = 8'(i);
      #2;
      if (i == 2) check("ae_at_2", almost_empty, 1);
      if (i == 3) check("ae_at_3", almost_empty, 0);
      tick();
    end
    wdat = 8'hEE;
    #2;
    check("fill_count", count, 32);
    check("fill_full",  full, 1);
    check("fill_ovf",   overflow, 1);
    tick();
    wr = 1'b0;
    #2;
    check("ovf_count", count, 32);

    // ---- drain 32: word i appears two cycles after its rd ----
    for (int i = 0; i < 34; i++) begin
      rd = (i < 32);
      #2;
      if (i < 32) check("drain_addr", mem_raddr, i);
      check("drain_valid", rd_valid, (i >= 2));
      if (i >= 2) check("drain_data", rd_data, i - 2);
      tick();
    end
    check("drain_count", count, 0);
    check("drain_empty", empty, 1);
    check("drain_wrap",  mem_raddr, 0);

    // ---- simultaneous push/pop at count=1 ----
    wr = 1'b1; wdat = 8'h20;
    tick();
    rd = 1'b1; wdat = 8'h21;
    #2;
    check("sim1_mem_re", mem_re, 1);
    check("sim1_addr0",  mem_raddr, 0);
    tick();
    wr = 1'b0; rd = 1'b0;
    #2;
    check("sim1_count", count, 1);
    check("sim1_addr1", mem_raddr, 1);
    tick();
    check("sim1_valid", rd_valid, 1);
    check("sim1_data",  rd_data, 8'h20);

    // ---- simultaneous at count=DEPTH: push dropped ----
    for (int i = 0; i < 31; i++) begin
      wr = 1'b1; wdat = 8'(i + 8'h40);
      tick();
    end
    wr = 1'b1; rd = 1'b1;
    #2;
    check("sim32_full", full, 1);
    check("sim32_ovf",  overflow, 1);
    check("sim32_re",   mem_re, 1);
    tick();
    #2;
    check("sim32_count", count, 31);
    check("sim32_nfull", full, 0);
    // Same again at DEPTH-1: both accepted, count unchanged.
    tick();
    wr = 1'b0; rd = 1'b0;
    #2;
    check("sim31_count", count, 31);

    // ---- reset mid-stream at count=5 ----
    rd = 1'b1;
    for (int i = 0; i < 26; i++) tick();
    #2;
    check("pre_rst_count", count, 5);
    check("pre_rst_valid", rd_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_count",  count, 0);
    check("mid_rst_valid",  rd_valid, 0);
    check("mid_rst_empty",  empty, 1);
    check("mid_rst_mem_re", mem_re, 0);
    check("mid_rst_ptr",    mem_raddr, 0);
    rd  = 1'b0;
    rst = 1'b0;
    tick();

    // ---- DEPTH=5 wrap: 12 push/pop pairs ----
    for (int k = 0; k < 16; k++) begin
      wr5   = (k <= 12);
      rd5   = (k >= 1 && k <= 13);
      wdat5 = 8'(k);
      #2;
      if (rd5) check("wrap_addr", mem_raddr5, (k - 1) % 5);
      if (k >= 1 && k <= 12) check("wrap_count", count5, 1);
      if (k >= 3) begin
        check("wrap_valid", rd_valid5, 1);
        check("wrap_no_x",  $isunknown(rd_data5), 0);
        check("wrap_data",  rd_data5, k - 3);
      end
      tick();
    end
    check("wrap_end_count", count5, 0);
`else
    // ---- FWFT: push 0xA5 into empty in cycle N -> visible in N+3 ----
    wr = 1'b1; wdat = 8'hA5;
    tick();
    wr = 1'b0;
    #2;
    check("fwft_n1_valid", rd_valid, 0);
    tick();
    check("fwft_n2_valid", rd_valid, 0);
    tick();
    check("fwft_n3_valid", rd_valid, 1);
    check("fwft_n3_data",  rd_data, 8'hA5);
    check("fwft_n3_empty", empty, 0);
    check("fwft_n3_count", count, 0);
    rd = 1'b1;
    #2;
    check("fwft_ack_re",  mem_re, 0);
    check("fwft_ack_unf", underflow, 0);
    tick();
    rd = 1'b0;
    #2;
    check("fwft_empty_valid", rd_valid, 0);
    check("fwft_empty",       empty, 1);

    // ---- FWFT capacity: 33 words fit ----
    for (int i = 0; i < 33; i++) begin
      wr = 1'b1; wdat = 8'(i);
      tick();
    end
    wr = 1'b0;
    tick();
    tick();
    check("fwft_cap_count", count, 32);
    check("fwft_cap_full",  full, 1);
    check("fwft_cap_valid", rd_valid, 1);
    check("fwft_cap_data",  rd_data, 0);
    wr = 1'b1;
    #2;
    check("fwft_cap_ovf", overflow, 1);
    tick();
    wr = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
